// File: rtl/mode_command_tx.sv
// Host-side encoder: turns single-cycle mode/rate/data commands into the
// ASCII byte stream for the mode controller, one byte per UART handshake.
module mode_command_tx #(
    parameter int GAP_CYCLES = 16,
    parameter bit LOWERCASE  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd_op,
    input  logic [7:0] i_cmd_arg,
    output logic       o_cmd_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_done,
    output logic       o_err
);

    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_LAST =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [7:0] CH_M = LOWERCASE ? 8'h6D : 8'h4D;
    localparam logic [7:0] CH_F = LOWERCASE ? 8'h66 : 8'h46;
    localparam logic [7:0] CH_C = LOWERCASE ? 8'h63 : 8'h43;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t          state;
    logic [2:0][7:0] seq;
    logic [1:0]      len;
    logic [1:0]      idx;
    logic [1:0]      idxNext;
    logic [CW-1:0]   gapCnt;

    logic            decOk;
    logic [1:0]      decLen;
    logic [2:0][7:0] decSeq;
    logic            dataClash;

    assign idxNext = idx + 2'd1;

    // Control codes in either case would confuse the far-end parser.
    always_comb begin
        dataClash = 1'b0;
        unique case (i_cmd_arg)
            8'h00, 8'h4D, 8'h6D, 8'h46,
            8'h66, 8'h43, 8'h63: dataClash = 1'b1;
            default:             dataClash = 1'b0;
        endcase
    end

    always_comb begin
        decOk  = 1'b0;
        decLen = 2'd0;
        decSeq = '0;
        unique case (i_cmd_op)
            2'b00: begin
                decOk     = !dataClash;
                decLen    = 2'd1;
                decSeq[0] = i_cmd_arg;
            end
            2'b01: begin
                decOk     = (i_cmd_arg[1:0] != 2'b11);
                decLen    = 2'd3;
                decSeq[0] = CH_M;
                decSeq[2] = CH_F;
                unique case (i_cmd_arg[1:0])
                    2'b00:   decSeq[1] = 8'h31;
                    2'b01:   decSeq[1] = 8'h35;
                    2'b10:   decSeq[1] = 8'h41;
                    default: decSeq[1] = 8'h00;
                endcase
            end
            2'b10: begin
                decOk     = 1'b1;
                decLen    = 2'd1;
                decSeq[0] = CH_C;
            end
            default: decOk = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            seq         <= '0;
            len         <= 2'd0;
            idx         <= 2'd0;
            gapCnt      <= '0;
            o_cmd_ready <= 1'b0;
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    o_cmd_ready <= 1'b1;
                    if (o_cmd_ready && i_cmd_valid) begin
                        if (decOk) begin
                            seq         <= decSeq;
                            len         <= decLen;
                            idx         <= 2'd0;
                            o_cmd_ready <= 1'b0;
                            o_tx_valid  <= 1'b1;
                            o_tx_data   <= decSeq[0];
                            state       <= SEND;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        idx <= idxNext;
                        if (GAP_CYCLES != 0) begin
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= 8'h00;
                            gapCnt     <= '0;
                            state      <= GAP;
                        end else if (idxNext == len) begin
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= 8'h00;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            o_tx_data <= seq[idxNext];
                        end
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        if (idx == len) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= seq[idx];
                            state      <= SEND;
                        end
                    end else begin
                        gapCnt <= gapCnt + CW'(1);
                    end
                end
                DONE: begin
                    o_cmd_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_command_tx.sv
// Directed bench for mode_command_tx: gap=2 uppercase instance and
// gap=0 lowercase instance, checked cycle by cycle.
module tb_mode_command_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       cmdValid = 1'b0;
    logic [1:0] cmdOp = 2'd0;
    logic [7:0] cmdArg = 8'h00;
    logic       txReady = 1'b1;
    logic       cmdReady, txValid, done, err;
    logic [7:0] txData;

    logic       cmdValidB = 1'b0;
    logic [1:0] cmdOpB = 2'd0;
    logic [7:0] cmdArgB = 8'h00;
    logic       txReadyB = 1'b1;
    logic       cmdReadyB, txValidB, doneB, errB;
    logic [7:0] txDataB;

    mode_command_tx #(.GAP_CYCLES(2), .LOWERCASE(1'b0)) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmdValid), .i_cmd_op(cmdOp), .i_cmd_arg(cmdArg),
        .o_cmd_ready(cmdReady), .o_tx_data(txData), .o_tx_valid(txValid),
        .i_tx_ready(txReady), .o_done(done), .o_err(err)
    );

    mode_command_tx #(.GAP_CYCLES(0), .LOWERCASE(1'b1)) dutB (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmdValidB), .i_cmd_op(cmdOpB), .i_cmd_arg(cmdArgB),
        .o_cmd_ready(cmdReadyB), .o_tx_data(txDataB), .o_tx_valid(txValidB),
        .i_tx_ready(txReadyB), .o_done(doneB), .o_err(errB)
    );

    // {valid, data, done, err, ready}
    logic [11:0] obsA, obsB;
    assign obsA = {txValid, txData, done, err, cmdReady};
    assign obsB = {txValidB, txDataB, doneB, errB, cmdReadyB};

    int nVec = 0;
    int nBad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk(logic v, logic [7:0] d, logic dn,
                                       logic e, logic r);
        return {v, d, dn, e, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rOp [5];
    logic [7:0] rArg [5];
    int sent, acc, sawValid;
    logic [7:0] d;

    initial begin
        rOp  = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        rArg = '{8'h00, 8'h03, 8'h4D, 8'h63, 8'h00};

        #2;
        check("rst_A", obsA, 12'h000);
        check("rst_B", obsB, 12'h000);
        tick();
        reset = 1'b1;
        tick();
        check("idle_A", obsA, pk(0, 8'h00, 0, 0, 1));
        check("idle_B", obsB, pk(0, 8'h00, 0, 0, 1));

        // rate 0x01, gap 2
        cmdValid = 1'b1; cmdOp = 2'd1; cmdArg = 8'h01; txReady = 1'b1;
        tick();
        cmdValid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            d = (k == 1) ? 8'h4D : (k == 4) ? 8'h35 : (k == 7) ? 8'h46 : 8'h00;
            check($sformatf("rate_k%0d", k), obsA,
                  pk(k == 1 || k == 4 || k == 7, d, k == 10, 0, k == 11));
            if (k < 11) tick();
        end

        // data 0x41 with 5 stalled cycles
        cmdValid = 1'b1; cmdOp = 2'd0; cmdArg = 8'h41; txReady = 1'b0;
        tick();
        cmdValid = 1'b0;
        sent = 0;
        for (int k = 1; k <= 10; k++) begin
            txReady = (k >= 6);
            check($sformatf("stall_k%0d", k), obsA,
                  pk(k <= 6, (k <= 6) ? 8'h41 : 8'h00, k == 9, 0, k == 10));
            if (txValid && txReady) sent++;
            if (k < 10) tick();
        end
        check("stall_once", sent, 1);
        txReady = 1'b1;

        // back-to-back rejects
        for (int j = 0; j <= 6; j++) begin
            cmdValid = (j < 5);
            if (j < 5) begin
                cmdOp = rOp[j]; cmdArg = rArg[j];
            end
            check($sformatf("rej_j%0d", j), obsA,
                  pk(0, 8'h00, 0, j >= 1 && j <= 5, 1));
            tick();
        end

        // busy: request held during a rate sequence
        cmdValid = 1'b1; cmdOp = 2'd1; cmdArg = 8'h00;
        tick();
        cmdOp = 2'd2;
        acc = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 12) cmdValid = 1'b0;
            d = (k == 1) ? 8'h4D : (k == 4) ? 8'h31 : (k == 7) ? 8'h46 :
                (k == 12) ? 8'h43 : 8'h00;
            check($sformatf("busy_k%0d", k), obsA,
                  pk(k == 1 || k == 4 || k == 7 || k == 12, d,
                     k == 10 || k == 15, 0, k == 11 || k == 16));
            if (cmdValid && cmdReady) acc++;
            if (k < 16) tick();
        end
        check("busy_once", acc, 1);

        // reset between 2nd and 3rd rate bytes
        cmdValid = 1'b1; cmdOp = 2'd1; cmdArg = 8'h02;
        tick();
        cmdValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            d = (k == 1) ? 8'h4D : (k == 4) ? 8'h41 : 8'h00;
            check($sformatf("rrst_k%0d", k), obsA,
                  pk(k == 1 || k == 4, d, 0, 0, 0));
            if (k < 5) tick();
        end
        #2 reset = 1'b0;
        #1 check("rrst_async", obsA, 12'h000);
        tick();
        tick();
        check("rrst_hold", obsA, 12'h000);
        reset = 1'b1;
        sawValid = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (txValid) sawValid++;
        end
        check("rrst_noF", sawValid, 0);
        check("rrst_ready", obsA, pk(0, 8'h00, 0, 0, 1));

        // lowercase clean, gap 0
        cmdValidB = 1'b1; cmdOpB = 2'd2; cmdArgB = 8'h00;
        check("clean_acc", cmdReadyB, 1);
        tick();
        cmdValidB = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("clean_k%0d", k), obsB,
                  pk(k == 1, (k == 1) ? 8'h63 : 8'h00, k == 2, 0, k == 3));
            if (k < 3) tick();
        end

        // lowercase rate 0x01, gap 0
        cmdValidB = 1'b1; cmdOpB = 2'd1; cmdArgB = 8'h01;
        tick();
        cmdValidB = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            d = (k == 1) ? 8'h6D : (k == 2) ? 8'h35 : (k == 3) ? 8'h66 : 8'h00;
            check($sformatf("lrate_k%0d", k), obsB,
                  pk(k <= 3, d, k == 4, 0, k == 5));
            if (k < 5) tick();
        end

        // uppercase code rejected even in lowercase mode
        cmdValidB = 1'b1; cmdOpB = 2'd0; cmdArgB = 8'h4D;
        tick();
        cmdValidB = 1'b0;
        check("lrej_err", obsB, pk(0, 8'h00, 0, 1, 1));
        tick();
        check("lrej_clr", obsB, pk(0, 8'h00, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
